// File: rtl/xdma_xfer_sequencer.sv
// GIF request-side beat sequencer: launches one write or read burst per descriptor,
// walks maddr one word per accepted beat and reports completion or a rejected descriptor.
module xdma_xfer_sequencer #(
    parameter int DWIDTH = 128,
    parameter int DW_IOB = 256,
    parameter int LW     = 16
) (
    input  logic                xclk,
    input  logic                xreset_n,
    input  logic                cfg_start,
    input  logic                cfg_abort,
    input  logic [3:0]          cfg_mode,
    input  logic [31:0]         cfg_sram_addr,
    input  logic [LW-1:0]       cfg_len,
    output logic                busy,
    output logic                done,
    output logic                err,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [DWIDTH-1:0]   wr_data,
    input  logic [DWIDTH/8-1:0] wr_strb,
    output logic                rd_valid,
    input  logic                rd_ready,
    output logic [DW_IOB-1:0]   rd_data,
    output logic [3:0]          dma_mode,
    output logic [31:0]         maddr_sram_start,
    output logic [31:0]         maddr,
    output logic                mread,
    output logic                mwrite,
    output logic [DWIDTH-1:0]   mdata,
    output logic [DWIDTH/8-1:0] mwstrb,
    output logic                mready,
    input  logic                saccept,
    input  logic                svalid,
    input  logic [DW_IOB-1:0]   sdata
);

    typedef enum logic [1:0] {S_IDLE, S_WR, S_RD, S_DONE} state_t;

    state_t            r_state, w_state_nx;
    logic [LW-1:0]     r_rem;
    logic [31:0]       r_maddr, r_sram_start;
    logic [3:0]        r_mode;
    logic              r_err, r_rd_valid;
    logic [DW_IOB-1:0] r_rd_data;

    logic w_is_wr, w_is_rd, w_legal, w_launch, w_reject;
    logic w_in_wr, w_in_rd, w_wr_fire, w_rd_fire, w_rd_take;
    logic w_unused;

    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    always_comb begin
        w_is_wr = 1'b0;
        w_is_rd = 1'b0;
        case (cfg_mode)
            4'd1, 4'd2, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9: w_is_wr = 1'b1;
            4'd3, 4'd4:                               w_is_rd = 1'b1;
            default:                                  ;
        endcase
    end

    assign w_legal  = (w_is_wr | w_is_rd) & (cfg_len != '0);
    assign w_launch = (r_state == S_IDLE) & cfg_start & w_legal;
    assign w_reject = (r_state == S_IDLE) & cfg_start & ~w_legal;

    assign w_in_wr = (r_state == S_WR);
    assign w_in_rd = (r_state == S_RD);
    assign mready  = w_in_wr | w_in_rd;
    assign busy    = mready;
    assign done    = (r_state == S_DONE);
    assign err     = r_err;

    assign mwrite   = w_in_wr & wr_valid;
    assign wr_ready = w_in_wr & saccept;
    assign mread    = w_in_rd & (r_rem != '0) & (~r_rd_valid | rd_ready);

    // Abort wins over a same-cycle fire: that beat is treated as never moved.
    assign w_wr_fire = mwrite & wr_ready & ~cfg_abort;
    assign w_rd_fire = mread & saccept & ~cfg_abort;
    assign w_rd_take = w_in_rd & r_rd_valid & rd_ready;

    assign mdata            = wr_data;
    assign mwstrb           = wr_strb;
    assign rd_valid         = r_rd_valid;
    assign rd_data          = r_rd_data;
    assign dma_mode         = r_mode;
    assign maddr_sram_start = r_sram_start;
    assign maddr            = r_maddr;
    assign w_unused         = svalid;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge xclk or negedge xreset_n) begin
        if (!xreset_n) r_state <= S_IDLE;
        else           r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        unique case (r_state)
            S_IDLE: if (w_launch) w_state_nx = w_is_wr ? S_WR : S_RD;
            S_WR: begin
                if (cfg_abort)                          w_state_nx = S_IDLE;
                else if (w_wr_fire && r_rem == LW'(1))  w_state_nx = S_DONE;
            end
            S_RD: begin
                if (cfg_abort)                          w_state_nx = S_IDLE;
                else if (r_rem == '0 && w_rd_take)      w_state_nx = S_DONE;
            end
            S_DONE:  w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge xclk or negedge xreset_n) begin
        if (!xreset_n) begin
            r_rem        <= '0;
            r_maddr      <= '0;
            r_sram_start <= '0;
            r_mode       <= '0;
            r_err        <= 1'b0;
            r_rd_valid   <= 1'b0;
            // NOTE: the read holding buffer is a single register, not a memory array, so it takes a reset value.
            r_rd_data    <= '0;
        end else begin
            r_err <= w_reject;
            if (w_launch) begin
                r_mode       <= cfg_mode;
                r_sram_start <= cfg_sram_addr;
                r_maddr      <= cfg_sram_addr;
                r_rem        <= cfg_len;
            end else if (cfg_abort && mready) begin
                r_rem      <= '0;
                r_rd_valid <= 1'b0;
            end else begin
                if (w_wr_fire || w_rd_fire) begin
                    r_maddr <= r_maddr + 32'd1;
                    r_rem   <= r_rem - LW'(1);
                end
                // A consume and a fire in one cycle keep the buffer full with the new beat.
                if (w_rd_fire) begin
                    r_rd_data  <= sdata;
                    r_rd_valid <= 1'b1;
                end else if (w_rd_take) begin
                    r_rd_valid <= 1'b0;
                end
            end
        end
    end

endmodule
